ibex_cpi_stack_sampler: RTL

//  Consumes the per-lane, per-cycle CPI-stack category strobes from the CPI tracer (base, icache, bpred,

---
 rtl/ibex_cpi_pkg.sv | 29 ++
 rtl/ibex_cpi_sample_fifo.sv | 72 +++++++
 rtl/ibex_cpi_stack_sampler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ibex_cpi_pkg.sv
// Shared types and constants for the CPI-stack sampler.
// Each sample record is seven count fields: the window length in cycles
// sits in the MSBs, followed by the six categories in enum order.
package ibex_cpi_pkg;

    localparam int CPI_N_CAT    = 6;
    localparam int CPI_CNT_W    = 16;
    localparam int CPI_N_FIELDS = CPI_N_CAT + 1;

    typedef enum logic [2:0] {
        BASE   = 3'd0,
        ICACHE = 3'd1,
        BPRED  = 3'd2,
        DCACHE = 3'd3,
        EX     = 3'd4,
        DEP    = 3'd5
    } cpi_cat_e;

    typedef struct packed {
        logic [CPI_CNT_W-1:0] win_cycles;
        logic [CPI_CNT_W-1:0] base;
        logic [CPI_CNT_W-1:0] icache;
        logic [CPI_CNT_W-1:0] bpred;
        logic [CPI_CNT_W-1:0] dcache;
        logic [CPI_CNT_W-1:0] ex;
        logic [CPI_CNT_W-1:0] dep;
    } cpi_sample_t;

endpackage

// File: rtl/ibex_cpi_sample_fifo.sv
// Small synchronous FIFO holding completed CPI samples until the sink takes them.
// The head entry comes straight out of registered storage, so it cannot change
// while it is being offered. A push into a full FIFO is still accepted when the
// head is popped on the same edge.
module ibex_cpi_sample_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  T                       push_data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output T                       data_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;
    logic             pop;
    logic             push_ok;

    // Handshake decode: pop on an accepted head, push if there is room or a slot frees up now
    always_comb begin
        full_o  = (level == (PTR_W + 1)'(DEPTH));
        valid_o = (level != '0);
        pop     = valid_o && ready_i;
        push_ok = push_i && (!full_o || pop);
        data_o  = mem[rd_ptr];
        level_o = level;
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO ahead of any push or pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Sample storage needs no reset; entries are only read once written
    always_ff @(posedge clk_i) begin
        if (!clear_i && push_ok) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/ibex_cpi_stack_sampler.sv
// Accumulates per-lane CPI-stack category strobes over fixed windows of
// non-inhibited cycles and snapshots the totals into a sample FIFO at each
// window close. Counts saturate; lost samples and one-hot violations are
// reported on sticky/saturating status outputs.
module ibex_cpi_stack_sampler
    import ibex_cpi_pkg::*;
#(
    parameter int N_LANES       = 1,
    parameter int CNT_W         = CPI_CNT_W,
    parameter int SAMPLE_PERIOD = 1024,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              inhibit_i,
    input  logic                              clear_i,
    input  logic [N_LANES-1:0]                base_i,
    input  logic [N_LANES-1:0]                icache_i,
    input  logic [N_LANES-1:0]                bpred_i,
    input  logic [N_LANES-1:0]                dcache_i,
    input  logic [N_LANES-1:0]                ex_i,
    input  logic [N_LANES-1:0]                dep_i,
    output logic                              sample_valid_o,
    input  logic                              sample_ready_i,
    output logic [CPI_N_FIELDS*CNT_W-1:0]     sample_o,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o,
    output logic [CNT_W-1:0]                  drop_cnt_o,
    output logic                              onehot_err_o
);

    localparam int SAMPLE_W = CPI_N_FIELDS * CNT_W;

    typedef logic [SAMPLE_W-1:0] sample_vec_t;

    logic [N_LANES-1:0] cat_strobe [CPI_N_CAT];
    logic [CNT_W-1:0]   acc_q      [CPI_N_CAT];
    logic [CNT_W-1:0]   acc_next   [CPI_N_CAT];
    logic [CNT_W-1:0]   pop_cnt;
    logic [CNT_W:0]     acc_sum;
    logic [CNT_W-1:0]   win_q;
    logic [CNT_W-1:0]   win_next;
    logic [CNT_W-1:0]   timer_q;
    logic [CNT_W-1:0]   drop_q;
    logic [2:0]         lane_cnt;
    logic               onehot_viol;
    logic               err_q;
    logic               close;
    logic               fifo_full;
    logic               head_pop;
    sample_vec_t        snapshot;

    // Gather the category strobes into an array indexed by category
    always_comb begin
        cat_strobe[BASE]   = base_i;
        cat_strobe[ICACHE] = icache_i;
        cat_strobe[BPRED]  = bpred_i;
        cat_strobe[DCACHE] = dcache_i;
        cat_strobe[EX]     = ex_i;
        cat_strobe[DEP]    = dep_i;
    end

    // Next accumulator values: add the lane popcount unless inhibited, saturating at all-ones
    always_comb begin
        pop_cnt = '0;
        acc_sum = '0;
        for (int c = 0; c < CPI_N_CAT; c++) begin
            pop_cnt = '0;
            if (!inhibit_i) begin
                for (int l = 0; l < N_LANES; l++) begin
                    pop_cnt = pop_cnt + CNT_W'(cat_strobe[c][l]);
                end
            end
            acc_sum     = {1'b0, acc_q[c]} + {1'b0, pop_cnt};
            acc_next[c] = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
        end
        win_next = (&win_q) ? win_q : win_q + CNT_W'(1);
    end

    // Flag any lane that raises more than one category in a non-inhibited cycle
    always_comb begin
        lane_cnt    = '0;
        onehot_viol = 1'b0;
        for (int l = 0; l < N_LANES; l++) begin
            lane_cnt = '0;
            for (int c = 0; c < CPI_N_CAT; c++) begin
                lane_cnt = lane_cnt + 3'(cat_strobe[c][l]);
            end
            if (lane_cnt > 3'd1) begin
                onehot_viol = 1'b1;
            end
        end
        if (inhibit_i) begin
            onehot_viol = 1'b0;
        end
    end

    // Window close detection and snapshot of the post-increment counts
    always_comb begin
        close    = !clear_i && !inhibit_i && (timer_q == CNT_W'(SAMPLE_PERIOD - 1));
        head_pop = sample_valid_o && sample_ready_i;
        snapshot = {win_next, acc_next[BASE], acc_next[ICACHE], acc_next[BPRED],
                    acc_next[DCACHE], acc_next[EX], acc_next[DEP]};
    end

    // Accumulators restart at every window close or clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CPI_N_CAT; c++) begin
                acc_q[c] <= '0;
            end
            win_q <= '0;
        end else if (clear_i || close) begin
            for (int c = 0; c < CPI_N_CAT; c++) begin
                acc_q[c] <= '0;
            end
            win_q <= '0;
        end else begin
            for (int c = 0; c < CPI_N_CAT; c++) begin
                acc_q[c] <= acc_next[c];
            end
            win_q <= win_next;
        end
    end

    // Window timer advances only on non-inhibited cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (clear_i || close) begin
            timer_q <= '0;
        end else if (!inhibit_i) begin
            timer_q <= timer_q + CNT_W'(1);
        end
    end

    // Drop counter and one-hot error are sticky across clear; only reset zeroes them
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (close && fifo_full && !head_pop && !(&drop_q)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
            if (onehot_viol) begin
                err_q <= 1'b1;
            end
        end
    end

    ibex_cpi_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (sample_vec_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (close),
        .push_data_i (snapshot),
        .valid_o     (sample_valid_o),
        .ready_i     (sample_ready_i),
        .data_o      (sample_o),
        .level_o     (fifo_level_o),
        .full_o      (fifo_full)
    );

    assign drop_cnt_o   = drop_q;
    assign onehot_err_o = err_q;

endmodule
